square_frame_accum: RTL and testbench
=====================================

// Module: square_frame_accum
// PURPOSE
//  Downstream consumer of the registered squarer (n -> n2). Accepts a stream of
//  squared samples, sums FRAME_LEN consecutive accepted samples into one frame
//  result, and presents each result on a valid/ready output. This yields
//  sum-of-squares (energy) per frame for the next stage.
// PARAMETERS
//  IN_W       8   width of squared input sample (matches squarer n2 width)
//  FRAME_LEN  4   samples per frame, legal range 2..256
//  SUM_W      16  width of frame sum; the sum wraps modulo 2^SUM_W
//  CNT_W      8   sample counter width; must satisfy 2^CNT_W >= FRAME_LEN
// PORTS
//  clk        in   1      rising-edge clock
//  rstn       in   1      asynchronous active-low reset
//  flush      in   1      sync; discard the partial frame
//  in_valid   in   1      in_data valid; upstream asserts it 1 cycle after n is applied
//  in_ready   out  1      block can accept in_data this cycle
//  in_data    in   IN_W   squared sample; ignored (may be X) when in_valid=0
//  out_valid  out  1      out_sum/out_ovf hold a completed frame
//  out_ready  in   1      downstream accepts the frame result
//  out_sum    out  SUM_W  frame sum of squares, mod 2^SUM_W
//  out_ovf    out  1      frame sum exceeded 2^SUM_W-1 (carry seen during the frame)
// BEHAVIOUR
//  Reset (rstn=0, async): acc=0, cnt=0, ovf_acc=0, out_valid=0, out_sum=0, out_ovf=0.
//   in_ready=1 from the first edge after release. X on in_data during reset is never sampled.
//  Accept: in_valid & in_ready at a rising edge.
//   acc <= acc + in_data (zero-extended, SUM_W bits).
//   ovf_acc |= carry out of bit SUM_W-1.
//   cnt <= cnt+1.
//  Frame end (accept with cnt==FRAME_LEN-1):
//   out_sum <= acc+in_data; out_ovf <= ovf_acc|carry; out_valid <= 1.
//   acc, cnt, ovf_acc <= 0.
//   Latency: result is visible the cycle after the final accept.
//  Output register: out_valid stays 1 and out_sum/out_ovf stay stable until
//   out_valid & out_ready. Then out_valid <= 0, unless a frame end occurs in the
//   same cycle; in that case the new result loads and out_valid stays 1 (no bubble).
//  Backpressure:
//   in_ready = !(cnt==FRAME_LEN-1 && out_valid && !out_ready).
//   Only the last sample of a frame stalls. Samples 0..FRAME_LEN-2 are always accepted.
//   in_ready is combinational from state and out_ready only, never from in_valid.
//  flush=1 at an edge:
//   acc, cnt, ovf_acc <= 0; any same-cycle accept is discarded.
//   The output register and handshake are unaffected; a held result is kept.
//   While flush=1, no frame end occurs.
//  in_valid=0: no state change except the output handshake.
//  Wrap: cnt never exceeds FRAME_LEN-1. The sum wraps silently; only out_ovf reports it.
//  Mid-frame reset: the partial frame and any pending result are lost.
//   The next frame starts counting from sample 0.
// TESTING
//  T1 FRAME_LEN=4, out_ready=1; in_data 9,25,49,225 on consecutive cycles
//   -> out_valid=1 for 1 cycle, one cycle after the 4th accept; out_sum=308, out_ovf=0.
//  T2 out_ready=0 holding 308; next frame 1,1,1,1
//   -> in_ready=0 while 4th sample pending, out_sum stable at 308.
//   Raise out_ready: 308 pops; next cycle out_sum=4.
//  T3 SUM_W=8; in_data 200,100,0,0 -> out_sum=44, out_ovf=1; next frame 1,1,1,1 -> out_ovf=0.
//  T4 accept 50,50; flush=1 one cycle; then 4,4,4,4 -> out_sum=16; no result from the 50s.
//  T5 accept 2 samples; pulse rstn=0 mid-cycle -> out_valid=0 immediately.
//   After release, 1,2,3,4 -> out_sum=10.
//  T6 out_valid=1, out_ready=1 in the same cycle the 4th sample is accepted
//   -> out_valid stays 1 and out_sum updates next cycle; no frame is dropped or duplicated.

Source files
------------

// File: rtl/square_frame_accum.sv
// square_frame_accum: sums FRAME_LEN accepted squared samples into one frame
// result (sum of squares, mod 2^SUM_W) with a sticky overflow flag, and holds
// each result in a valid/ready output register.
module square_frame_accum #(
    parameter int IN_W      = 8,
    parameter int FRAME_LEN = 4,
    parameter int SUM_W     = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    logic [SUM_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf_acc;
    logic [SUM_W:0]   sum_next;
    logic             last_slot;
    logic             accept;
    logic             frame_end;

    // One extra bit on the adder captures the carry out of the top sum bit.
    assign sum_next  = {1'b0, acc} + {{(SUM_W + 1 - IN_W){1'b0}}, in_data};

    // Only the final sample of a frame can stall: it needs the output slot free.
    assign last_slot = (cnt == LAST);
    assign in_ready  = !(last_slot && out_valid && !out_ready);

    // Flush discards any same-cycle sample, so it can never close a frame.
    assign accept    = in_valid && in_ready && !flush;
    assign frame_end = accept && last_slot;

    // Running accumulator, sample counter and sticky carry for the open frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc     <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
        end else if (flush || frame_end) begin
            acc     <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
        end else if (accept) begin
            acc     <= sum_next[SUM_W-1:0];
            cnt     <= cnt + CNT_W'(1);
            ovf_acc <= ovf_acc | sum_next[SUM_W];
        end
    end

    // Output register: a new frame result loads even while the old one pops,
    // so back-to-back frames leave no bubble on out_valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else if (frame_end) begin
            out_valid <= 1'b1;
            out_sum   <= sum_next[SUM_W-1:0];
            out_ovf   <= ovf_acc | sum_next[SUM_W];
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_square_frame_accum.sv
// Directed bench for square_frame_accum. Two instances share all inputs:
// dut_a uses SUM_W=16, dut_b uses SUM_W=8 to exercise sum wrap and out_ovf.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_square_frame_accum;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_ovf;
    logic [15:0] a_out_sum;
    logic        b_in_ready, b_out_valid, b_out_ovf;
    logic [7:0]  b_out_sum;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    square_frame_accum #(.IN_W(8), .FRAME_LEN(4), .SUM_W(16), .CNT_W(8)) dut_a (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_sum(a_out_sum), .out_ovf(a_out_ovf)
    );

    square_frame_accum #(.IN_W(8), .FRAME_LEN(4), .SUM_W(8), .CNT_W(8)) dut_b (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_sum(b_out_sum), .out_ovf(b_out_ovf)
    );

    // Present one sample (called at a falling edge), wait for in_ready, and
    // return at the falling edge after the accepting rising edge.
    task automatic send(input logic [7:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        #1;
        while (!a_in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL send_timeout got=in_ready_low want=accept data=%0d", d);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = 'x;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 'x; out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", a_out_valid); end
        total++; if (a_out_sum !== 16'd0) begin bad++; $display("FAIL rst_sum got=%0d want=0", a_out_sum); end
        total++; if (a_out_ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b want=0", a_out_ovf); end
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", a_in_ready); end
    endtask

    task automatic test_frame();
        out_ready = 1'b1;
        send(8'd9);
        send(8'd25);
        send(8'd49);
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL t1_early_valid got=%b want=0", a_out_valid); end
        send(8'd225);
        total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL t1_valid got=%b want=1", a_out_valid); end
        total++; if (a_out_sum !== 16'd308) begin bad++; $display("FAIL t1_sum got=%0d want=308", a_out_sum); end
        total++; if (a_out_ovf !== 1'b0) begin bad++; $display("FAIL t1_ovf got=%b want=0", a_out_ovf); end
        idle();
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL t1_pulse got=%b want=0", a_out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(8'd9); send(8'd25); send(8'd49); send(8'd225);
        send(8'd1); send(8'd1); send(8'd1);
        in_valid = 1'b1; in_data = 8'd1;
        #1;
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL t2_stall got=%b want=0", a_in_ready); end
        @(negedge clk);
        total++; if (a_out_sum !== 16'd308) begin bad++; $display("FAIL t2_hold_sum got=%0d want=308", a_out_sum); end
        total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL t2_hold_valid got=%b want=1", a_out_valid); end
        out_ready = 1'b1;
        #1;
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL t2_release got=%b want=1", a_in_ready); end
        @(negedge clk);
        total++; if (a_out_sum !== 16'd4) begin bad++; $display("FAIL t2_next_sum got=%0d want=4", a_out_sum); end
        total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL t2_next_valid got=%b want=1", a_out_valid); end
        idle();
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL t2_drain got=%b want=0", a_out_valid); end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        send(8'd200); send(8'd100); send(8'd0); send(8'd0);
        total++; if (b_out_sum !== 8'd44) begin bad++; $display("FAIL t3_wrap_sum got=%0d want=44", b_out_sum); end
        total++; if (b_out_ovf !== 1'b1) begin bad++; $display("FAIL t3_wrap_ovf got=%b want=1", b_out_ovf); end
        total++; if (a_out_sum !== 16'd300) begin bad++; $display("FAIL t3_wide_sum got=%0d want=300", a_out_sum); end
        total++; if (a_out_ovf !== 1'b0) begin bad++; $display("FAIL t3_wide_ovf got=%b want=0", a_out_ovf); end
        send(8'd1); send(8'd1); send(8'd1); send(8'd1);
        total++; if (b_out_sum !== 8'd4) begin bad++; $display("FAIL t3_next_sum got=%0d want=4", b_out_sum); end
        total++; if (b_out_ovf !== 1'b0) begin bad++; $display("FAIL t3_ovf_clear got=%b want=0", b_out_ovf); end
        idle();
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        send(8'd50); send(8'd50);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'd50;
        @(negedge clk);
        flush = 1'b0;
        send(8'd4); send(8'd4); send(8'd4);
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL t4_no_stale got=%b want=0", a_out_valid); end
        send(8'd4);
        total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL t4_valid got=%b want=1", a_out_valid); end
        total++; if (a_out_sum !== 16'd16) begin bad++; $display("FAIL t4_sum got=%0d want=16", a_out_sum); end
        idle();
    endtask

    task automatic test_midreset();
        out_ready = 1'b0;
        send(8'd1); send(8'd1); send(8'd1); send(8'd2);
        send(8'd2); send(8'd3);
        idle();
        total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL t5_pending got=%b want=1", a_out_valid); end
        #2 rstn = 1'b0;
        #1;
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL t5_async_valid got=%b want=0", a_out_valid); end
        total++; if (a_out_sum !== 16'd0) begin bad++; $display("FAIL t5_async_sum got=%0d want=0", a_out_sum); end
        @(negedge clk);
        rstn = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        total++; if (a_out_sum !== 16'd10) begin bad++; $display("FAIL t5_sum got=%0d want=10", a_out_sum); end
        total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL t5_valid got=%b want=1", a_out_valid); end
    endtask

    task automatic test_back_to_back();
        // Result 10 from the previous task is still held; stall the pop.
        out_ready = 1'b0;
        send(8'd5); send(8'd6); send(8'd7);
        total++; if (a_out_sum !== 16'd10) begin bad++; $display("FAIL t6_hold got=%0d want=10", a_out_sum); end
        out_ready = 1'b1;
        send(8'd8);
        total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL t6_no_bubble got=%b want=1", a_out_valid); end
        total++; if (a_out_sum !== 16'd26) begin bad++; $display("FAIL t6_sum got=%0d want=26", a_out_sum); end
        total++; if (b_out_sum !== 8'd26) begin bad++; $display("FAIL t6_b_sum got=%0d want=26", b_out_sum); end
        idle();
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL t6_single_pop got=%b want=0", a_out_valid); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_backpressure();
        test_wrap();
        test_flush();
        test_midreset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
